// File: rtl/cache_pkg.sv
// Shared geometry, state encoding and way-select constants for the two-way
// write-through data cache.
package cache_pkg;

    localparam int unsigned CACHE_SETS  = 64;
    localparam int unsigned CACHE_TAG_W = 10;
    localparam int unsigned WORD_BIT    = 2;
    localparam int unsigned INDEX_LSB   = 3;

    localparam logic WAY0 = 1'b0;
    localparam logic WAY1 = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        READ_MISS,
        WRITE
    } cache_state_t;

endpackage

// File: rtl/cache_array.sv
// Two-way tag/data storage with per-set LRU bit, combinational lookup and
// synchronous fill / word update.
module cache_array
    import cache_pkg::*;
#(
    parameter int unsigned SETS  = CACHE_SETS,
    parameter int unsigned TAG_W = CACHE_TAG_W,
    localparam int unsigned IDX_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] index,
    input  logic [TAG_W-1:0] tag,
    input  logic             word_sel,
    output logic             hit0,
    output logic             hit1,
    output logic [31:0]      hit_word,
    output logic             victim,
    input  logic             fill_en,
    input  logic             fill_way,
    input  logic [63:0]      fill_line,
    input  logic             upd_en,
    input  logic             upd_way,
    input  logic [31:0]      upd_word,
    input  logic             lru_en,
    input  logic             lru_way
);

    logic [SETS-1:0]  valid [2];
    logic [SETS-1:0]  lru;
    logic [TAG_W-1:0] tags  [2][SETS];
    logic [63:0]      data  [2][SETS];
    logic [63:0]      line;

    always_comb begin
        hit0     = valid[0][index] && (tags[0][index] == tag);
        hit1     = valid[1][index] && (tags[1][index] == tag);
        line     = hit1 ? data[1][index] : data[0][index];
        hit_word = word_sel ? line[63:32] : line[31:0];
        // An invalid way is always preferred over evicting a live line.
        if (!valid[0][index])
            victim = WAY0;
        else if (!valid[1][index])
            victim = WAY1;
        else
            victim = lru[index];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid[0] <= '0;
            valid[1] <= '0;
            lru      <= '0;
        end else begin
            if (fill_en)
                valid[fill_way][index] <= 1'b1;
            if (lru_en)
                lru[index] <= ~lru_way;
        end
    end

    // Contents are not cleared by reset, but an update racing reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (fill_en) begin
                tags[fill_way][index] <= tag;
                data[fill_way][index] <= fill_line;
            end else if (upd_en) begin
                if (word_sel)
                    data[upd_way][index][63:32] <= upd_word;
                else
                    data[upd_way][index][31:0]  <= upd_word;
            end
        end
    end

endmodule

// File: rtl/cache_controller.sv
// Write-through, no-write-allocate two-way data cache between the MEM stage
// and the SRAM controller.
module cache_controller
    import cache_pkg::*;
#(
    parameter int unsigned SETS  = CACHE_SETS,
    parameter int unsigned TAG_W = CACHE_TAG_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        read_en,
    output logic        write_en,
    input  logic [63:0] sram_rdata,
    input  logic        sram_ready
);

    localparam int unsigned IDX_W = $clog2(SETS);

    cache_state_t     state, next_state;
    logic [IDX_W-1:0] index;
    logic [TAG_W-1:0] tag;
    logic             word_sel;
    logic             hit0, hit1, hit, hit_way, victim;
    logic [31:0]      hit_word;
    logic             fill_en, upd_en, lru_en, lru_way;

    assign index    = address[INDEX_LSB +: IDX_W];
    assign tag      = address[INDEX_LSB + IDX_W +: TAG_W];
    assign word_sel = address[WORD_BIT];
    assign hit      = hit0 | hit1;
    assign hit_way  = hit1 ? WAY1 : WAY0;

    cache_array #(
        .SETS  (SETS),
        .TAG_W (TAG_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .index     (index),
        .tag       (tag),
        .word_sel  (word_sel),
        .hit0      (hit0),
        .hit1      (hit1),
        .hit_word  (hit_word),
        .victim    (victim),
        .fill_en   (fill_en),
        .fill_way  (victim),
        .fill_line (sram_rdata),
        .upd_en    (upd_en),
        .upd_way   (hit_way),
        .upd_word  (wdata),
        .lru_en    (lru_en),
        .lru_way   (lru_way)
    );

    // Enables are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            read_en  <= 1'b0;
            write_en <= 1'b0;
        end else begin
            state    <= next_state;
            read_en  <= (next_state == READ_MISS);
            write_en <= (next_state == WRITE);
        end
    end

    always_comb begin
        next_state   = state;
        ready        = 1'b1;
        rdata        = '0;
        fill_en      = 1'b0;
        upd_en       = 1'b0;
        lru_en       = 1'b0;
        lru_way      = WAY0;
        sram_address = (state == WRITE) ? address : {address[31:3], 3'b000};
        sram_wdata   = wdata;
        case (state)
            IDLE: begin
                if (MEM_W_EN) begin
                    next_state = WRITE;
                    ready      = 1'b0;
                end else if (MEM_R_EN) begin
                    if (hit) begin
                        rdata   = hit_word;
                        lru_en  = 1'b1;
                        lru_way = hit_way;
                    end else begin
                        next_state = READ_MISS;
                        ready      = 1'b0;
                    end
                end
            end
            READ_MISS: begin
                ready = sram_ready;
                if (sram_ready) begin
                    next_state = IDLE;
                    rdata      = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
                    fill_en    = 1'b1;
                    lru_en     = 1'b1;
                    lru_way    = victim;
                end
            end
            WRITE: begin
                ready = sram_ready;
                if (sram_ready) begin
                    next_state = IDLE;
                    if (hit) begin
                        upd_en  = 1'b1;
                        lru_en  = 1'b1;
                        lru_way = hit_way;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: doc/cache_controller.md
# cache_controller

Two-way set-associative, write-through, no-write-allocate data cache between the MEM pipeline stage and the SRAM controller. It serves read hits in the same cycle. On read misses it fetches a 64-bit line, two 32-bit words, over the SRAM controller's enable/ready handshake. It forwards every write to SRAM and stalls the pipeline through the `ready` output until each SRAM transaction finishes.

## Interface
Parameters:
- `SETS`, default 64: number of sets; index is `address[8:3]`.
- `TAG_W`, default 10: tag width; tag is `address[18:9]`.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: reset is synchronous and active-high.
- `address`  in  32: data-memory byte address; bit 2 selects the word, bits [1:0] are ignored.
- `wdata`  in  32: store data.
- `MEM_R_EN`  in  1: load request, held until `ready`=1.
- `MEM_W_EN`  in  1: store request, held until `ready`=1.
- `rdata`  out  32: load data, valid when `ready`=1 for a load.
- `ready`  out  1: 0 stalls the pipeline.
- `sram_address`  out  32: address to the SRAM controller.
- `sram_wdata`  out  32: store data to the SRAM controller.
- `read_en`  out  1: SRAM line-read request.
- `write_en`  out  1: SRAM word-write request.
- `sram_rdata`  in  64: line from SRAM; bits [31:0] are word 0, bits [63:32] are word 1.
- `sram_ready`  in  1: SRAM done; sampled only while `read_en` or `write_en` is driven.

## Operation
- Storage per set and way: `valid`, `tag[TAG_W-1:0]`, `data[63:0]`. Each set has one `lru` bit, where 0 means way 0 is least recently used.
- Hit: `valid` is set and the tag matches in either way. Both ways are never valid with the same tag.
- FSM states:
  - IDLE → READ_MISS on `MEM_R_EN` with a miss.
  - IDLE → WRITE on `MEM_W_EN`, hit or miss.
  - READ_MISS → IDLE when `sram_ready`=1.
  - WRITE → IDLE when `sram_ready`=1.
- If `MEM_R_EN` and `MEM_W_EN` are both asserted, the write wins.
- Read hit (IDLE):
  - `ready`=1 and `rdata`=selected word, combinationally.
  - At the edge, `lru` points to the other way.
  - No SRAM traffic.
- Read miss:
  - `read_en`=1 throughout READ_MISS.
  - `sram_address`={`address[31:3]`,3'b000}.
  - On the `sram_ready` cycle, `ready`=1 and `rdata`=selected word of `sram_rdata`.
  - At that edge the line fills the victim way and `lru` points to the other way.
  - Victim choice: the invalid way (way 0 first if both are invalid), otherwise the way indicated by `lru`.
- Write:
  - `write_en`=1 throughout WRITE, with `sram_address`=`address` and `sram_wdata`=`wdata`.
  - On the `sram_ready` cycle, `ready`=1.
  - If the write hits, the same edge updates the selected word in the hitting way and flips `lru` away from that way.
  - A write miss allocates nothing.
- `read_en` and `write_en` are registered state decodes. They are never both 1, and are 0 in IDLE.
- No request: `ready`=1 and `rdata`=0.

## Timing
- Reset: state=IDLE; all `valid`=0; all `lru`=0.
- Reset output values: `read_en`=0, `write_en`=0, `ready`=1 (with no request), `rdata`=0.
- Data and tag arrays are not cleared by reset.
- Read hit latency: 0 stall cycles.
- Miss and write latency:
  - Cycle 0: detect, `ready`=0.
  - Cycle 1 onward: enable driven.
  - Completes in the cycle `sram_ready`=1.
  - Total stall is 1 + SRAM latency.
- `sram_ready` is ignored in IDLE; the SRAM controller reports ready while idle.
- Request inputs are assumed stable while `ready`=0; changes are not tracked.
- Reset mid-transaction:
  - The next edge returns to IDLE and drops the enables.
  - The in-flight fill or write-hit update is discarded.
  - All lines become invalid.
- The SRAM reply edge always finishes in IDLE, so a new request in the following cycle starts clean.

## Structure
- Package `cache_pkg` holds:
  - geometry constants: `SETS`, `TAG_W`, and the index and offset bit positions;
  - the state encoding `cache_state_t` = {IDLE, READ_MISS, WRITE};
  - the `way_sel` helper constants.
- One sub-module, `cache_array`:
  - holds the two ways' `valid`/`tag`/`data` and the `lru` bits;
  - combinational lookup returns `hit0`, `hit1`, the selected word and the victim way;
  - synchronous fill, word update and `lru` update;
  - synchronous `valid` clear on `rst`.
- `cache_controller` holds the FSM, victim/enable muxing and the pipeline-side outputs.

## Test plan
- **Cold miss then hit.**
  - Stimulus: after reset, read 0x10; the SRAM model returns 64'h00000002_00000001 after 5 cycles.
  - Required: `read_en` rises in cycle 1 with `sram_address`=0x10; on the `sram_ready` cycle, `ready`=1 and `rdata`=0x1.
  - Then read 0x14: `ready`=1 in the same cycle, `rdata`=0x2, `read_en` stays 0.
- **Write hit.**
  - Stimulus: with line 0x10 cached, write 0x14 with 0xDEADBEEF.
  - Required: `write_en` is held until `sram_ready` with `sram_wdata`=0xDEADBEEF.
  - A following read of 0x14 hits and returns 0xDEADBEEF.
- **Write miss.**
  - Stimulus: write 0x40 with 0x5, then read 0x40.
  - Required: the read misses and `read_en` is asserted; no line is allocated by the write.
- **LRU replacement.**
  - Stimulus, same set 0: read 0x000, read 0x200, read 0x000 (hit), read 0x400 (miss).
  - Required: 0x400 replaces 0x200's way; 0x000 then hits and 0x200 misses.
- **Reset during READ_MISS.**
  - Required: the edge after `rst` gives `read_en`=0 and state IDLE; a subsequent read of the previously cached 0x10 misses.
- **Simultaneous `MEM_R_EN` and `MEM_W_EN`** on 0x20.
  - Required: `write_en`=1 and `read_en`=0 throughout; `ready` returns on `sram_ready`.
